// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write master.
package sccb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StId,
      StAddr,
      StData,
      StStop
   } sccb_state_e;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam int unsigned SCCB_BITS_PER_BYTE = 9;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: one-cycle pulse every DIV clocks, restartable.
module sccb_tick_gen #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   // Free-running count that wraps at DIV-1; with DIV=1 it stays at zero so tick is always high.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: START, ID, register address, register data, STOP.
import sccb_pkg::*;

module sccb_write_master #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h21,
   parameter int unsigned CLK_FREQ   = 1_000_000,
   parameter int unsigned I2C_FREQ   = 250_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i2c_exec,
   input  logic [15:0] i2c_data,
   output logic        i2c_done,
   output logic        i2c_busy,
   output logic        ack_err,
   output logic        scl,
   output logic        sda_o,
   output logic        sda_oe,
   input  logic        sda_i
);

   localparam int unsigned DIV = CLK_FREQ / (4 * I2C_FREQ);
   localparam logic [3:0] ACK_BIT = 4'(SCCB_BITS_PER_BYTE - 1);

   sccb_state_e state_q, state_d;
   logic [1:0]  qtr_q, qtr_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] data_q, data_d;
   logic [7:0]  shift_q, shift_d;
   logic        scl_q, scl_d, sda_o_q, sda_o_d, sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
   logic        tick, clear, ack_slot, last_qtr;

   sccb_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick)
   );

   assign ack_slot = (bit_q == ACK_BIT);
   assign last_qtr = tick && (qtr_q == Q3);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: each phase ends on its final quarter (bytes also need the ACK slot).
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (i2c_exec) state_d = StStart;
         StStart: if (last_qtr) state_d = StId;
         StId:    if (last_qtr && ack_slot) state_d = StAddr;
         StAddr:  if (last_qtr && ack_slot) state_d = StData;
         StData:  if (last_qtr && ack_slot) state_d = StStop;
         StStop:  if (last_qtr) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output/datapath next values: pins are computed per quarter and registered on the tick edge.
   always_comb begin
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      data_d    = data_q;
      shift_d   = shift_q;
      scl_d     = scl_q;
      sda_o_d   = sda_o_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      clear     = 1'b0;
      case (state_q)
         StIdle: begin
            scl_d    = 1'b1;
            sda_o_d  = 1'b1;
            sda_oe_d = 1'b1;
            // busy still set here means STOP just finished: close out the transaction.
            if (busy_q) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
            if (i2c_exec) begin
               data_d    = i2c_data;
               ack_err_d = 1'b0;
               busy_d    = 1'b1;
               qtr_d     = Q0;
               bit_d     = '0;
               shift_d   = {SLAVE_ADDR, 1'b0};
               clear     = 1'b1;
            end
         end
         StStart: begin
            if (tick) begin
               qtr_d    = qtr_q + 2'd1;
               scl_d    = (qtr_q != Q3);
               sda_o_d  = (qtr_q == Q0) || (qtr_q == Q1);
               sda_oe_d = 1'b1;
            end
         end
         StId, StAddr, StData: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               case (qtr_q)
                  Q0: begin
                     scl_d    = 1'b0;
                     sda_o_d  = ack_slot | shift_q[7];
                     sda_oe_d = ~ack_slot;
                  end
                  Q1: scl_d = 1'b1;
                  Q2: begin
                     scl_d = 1'b1;
                     if (ack_slot && sda_i) ack_err_d = 1'b1;
                  end
                  default: begin
                     scl_d = 1'b0;
                     if (ack_slot) begin
                        bit_d   = '0;
                        shift_d = (state_q == StId) ? data_q[15:8] : data_q[7:0];
                     end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                     end
                  end
               endcase
            end
         end
         StStop: begin
            if (tick) begin
               qtr_d    = qtr_q + 2'd1;
               scl_d    = (qtr_q != Q0);
               sda_o_d  = (qtr_q == Q2) || (qtr_q == Q3);
               sda_oe_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and pin registers; reset releases the bus to idle levels without a STOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         qtr_q     <= Q0;
         bit_q     <= '0;
         data_q    <= '0;
         shift_q   <= '0;
         scl_q     <= 1'b1;
         sda_o_q   <= 1'b1;
         sda_oe_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         shift_q   <= shift_d;
         scl_q     <= scl_d;
         sda_o_q   <= sda_o_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
      end
   end

   assign scl      = scl_q;
   assign sda_o    = sda_o_q;
   assign sda_oe   = sda_oe_q;
   assign i2c_busy = busy_q;
   assign i2c_done = done_q;
   assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_sccb_write_master.sv
// Self-checking bench for sccb_write_master with a timeline model and a bench-side slave.
module tb_sccb_write_master;

   localparam int DIV  = 1;
   localparam int TLEN = 116;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, i2c_exec = 1'b0;
   logic [15:0] i2c_data = 16'h0;
   logic        i2c_done, i2c_busy, ack_err, scl, sda_o, sda_oe, sda_i;
   logic        exec4 = 1'b0;
   logic        done4, busy4, ack_err4, scl4, sda_o4, sda_oe4, sda_i4;

   sccb_write_master dut (
      .clk (clk), .rst (rst), .i2c_exec (i2c_exec), .i2c_data (i2c_data),
      .i2c_done (i2c_done), .i2c_busy (i2c_busy), .ack_err (ack_err),
      .scl (scl), .sda_o (sda_o), .sda_oe (sda_oe), .sda_i (sda_i)
   );

   sccb_write_master #(
      .CLK_FREQ (4_000_000), .I2C_FREQ (250_000)
   ) dut4 (
      .clk (clk), .rst (rst), .i2c_exec (exec4), .i2c_data (16'h1280),
      .i2c_done (done4), .i2c_busy (busy4), .ack_err (ack_err4),
      .scl (scl4), .sda_o (sda_o4), .sda_oe (sda_oe4), .sda_i (sda_i4)
   );

   int tests = 0, fails = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Bench slave: ACKs every slot except the byte chosen by nack_byte.
   int rise_cnt = 0, nack_byte = -1, ack_b;
   logic slave_bit;
   always_comb begin
      ack_b     = (rise_cnt == 0) ? 0 : (rise_cnt - 1) / 9;
      slave_bit = (nack_byte >= 0) && (ack_b == nack_byte);
   end
   assign sda_i  = sda_oe ? sda_o : slave_bit;
   assign sda_i4 = sda_oe4 ? sda_o4 : 1'b0;

   // Bus monitor: START/STOP detection and byte decode on SCL rising edges.
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0] shreg = 8'h0;
   logic [7:0] bytes_q[$];
   int start_cnt = 0, stop_cnt = 0, done_cnt = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         if (prev_scl && scl && prev_sda && !sda_i) begin
            start_cnt <= start_cnt + 1;
            rise_cnt  <= 0;
         end else if (prev_scl && scl && !prev_sda && sda_i) begin
            stop_cnt <= stop_cnt + 1;
         end
         if (!prev_scl && scl) begin
            rise_cnt <= rise_cnt + 1;
            if (rise_cnt % 9 < 8) shreg <= {shreg[6:0], sda_i};
            if (rise_cnt % 9 == 7) bytes_q.push_back({shreg[6:0], sda_i});
         end
         if (i2c_done === 1'b1) done_cnt <= done_cnt + 1;
      end
      prev_scl <= scl;
      prev_sda <= sda_i;
   end

   // Model: remembers the acceptance edge and derives every output from elapsed time.
   int cyc = 0, m_acc = -1000000, m_done_at = -1, m_nack = -1;
   logic [7:0] m_b1 = 8'h0, m_b2 = 8'h0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_acc     <= -1000000;
         m_done_at <= -1;
         m_nack    <= -1;
      end else if (i2c_exec && (cyc - m_acc) > TLEN * DIV) begin
         m_acc     <= cyc;
         m_done_at <= cyc + TLEN * DIV + 1;
         m_nack    <= nack_byte;
         m_b1      <= i2c_data[15:8];
         m_b2      <= i2c_data[7:0];
      end
   end

   always @(negedge clk) begin
      int e, t, k, j, b, bt, qq;
      logic es, eo, eoe;
      logic [7:0] by;
      if (chk_en) begin
         e   = cyc - 1;
         t   = e - m_acc;
         k   = (t >= DIV && t <= TLEN * DIV) ? (t / DIV) - 1 : -1;
         es  = 1'b1; eo = 1'b1; eoe = 1'b1;
         if (k >= 0 && k < 4) begin
            es = (k != 3);
            eo = (k < 2);
         end else if (k >= TLEN - 4) begin
            j  = k - (TLEN - 4);
            es = (j != 0);
            eo = (j >= 2);
         end else if (k >= 4) begin
            j  = k - 4;
            b  = j / 36;
            bt = (j % 36) / 4;
            qq = j % 4;
            es = (qq == 1) || (qq == 2);
            by = (b == 0) ? 8'h42 : (b == 1) ? m_b1 : m_b2;
            if (bt == 8) eoe = 1'b0;
            else eo = by[7 - bt];
         end
         check("scl", 32'(scl), 32'(es));
         check("sda_oe", 32'(sda_oe), 32'(eoe));
         if (eoe) check("sda_o", 32'(sda_o), 32'(eo));
         check("busy", 32'(i2c_busy), 32'(t >= 0 && t <= TLEN * DIV));
         check("done", 32'(i2c_done), 32'(e == m_done_at));
         check("ack_err", 32'(ack_err), 32'(m_nack >= 0 && t >= DIV * (39 + 36 * m_nack)));
      end
   end

   // One write; optionally pulses a colliding request; returns cycles from acceptance to done.
   task automatic run_write(input logic [15:0] d, input int collide_at, output int lat);
      i2c_data = d;
      i2c_exec = 1'b1;
      cycle();
      i2c_exec = 1'b0;
      lat = -1;
      for (int n = 1; n <= 400; n++) begin
         if (n == collide_at) begin
            i2c_data = 16'h3d03;
            i2c_exec = 1'b1;
         end
         cycle();
         i2c_exec = 1'b0;
         if (i2c_done === 1'b1) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) check("done_timeout", 32'hffffffff, 32'd117);
   endtask

   task automatic check_bytes(input string name, input int base, input logic [7:0] b1,
                              input logic [7:0] b2);
      check({name, "_nbytes"}, 32'(bytes_q.size() - base), 32'd3);
      if (bytes_q.size() >= base + 3) begin
         check({name, "_id"}, 32'(bytes_q[base]), 32'h42);
         check({name, "_addr"}, 32'(bytes_q[base + 1]), 32'(b1));
         check({name, "_data"}, 32'(bytes_q[base + 2]), 32'(b2));
      end
   endtask

   initial begin
      int lat, base, s0, p0, d0, r1, r2, lat4;
      logic ps;

      cycle();
      chk_en = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_busy", 32'(i2c_busy), 32'd0);
      check("rst_done", 32'(i2c_done), 32'd0);

      // Single write with ACKs everywhere.
      base = bytes_q.size(); s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
      run_write(16'h1280, 0, lat);
      check("single_latency", 32'(lat), 32'd117);
      check("single_busy_at_done", 32'(i2c_busy), 32'd0);
      repeat (3) cycle();
      check_bytes("single", base, 8'h12, 8'h80);
      check("single_starts", 32'(start_cnt - s0), 32'd1);
      check("single_stops", 32'(stop_cnt - p0), 32'd1);
      check("single_dones", 32'(done_cnt - d0), 32'd1);
      check("single_ack_err", 32'(ack_err), 32'd0);

      // NACK in the ADDR ACK slot: transaction still completes.
      nack_byte = 1;
      base = bytes_q.size(); d0 = done_cnt;
      run_write(16'h3d03, 0, lat);
      nack_byte = -1;
      check("nack_latency", 32'(lat), 32'd117);
      check("nack_ack_err_at_done", 32'(ack_err), 32'd1);
      repeat (10) cycle();
      check("nack_ack_err_sticky", 32'(ack_err), 32'd1);
      check_bytes("nack", base, 8'h3d, 8'h03);
      check("nack_dones", 32'(done_cnt - d0), 32'd1);

      // Busy collision: request at cycle 40 must be ignored.
      base = bytes_q.size(); d0 = done_cnt;
      run_write(16'h1280, 40, lat);
      check("collide_latency", 32'(lat), 32'd117);
      check("collide_ack_err_cleared", 32'(ack_err), 32'd0);
      repeat (130) cycle();
      check_bytes("collide", base, 8'h12, 8'h80);
      check("collide_dones", 32'(done_cnt - d0), 32'd1);

      // Back-to-back: request raised on the done cycle.
      base = bytes_q.size(); d0 = done_cnt;
      run_write(16'h1280, 0, lat);
      i2c_data = 16'h1500;
      i2c_exec = 1'b1;
      cycle();
      i2c_exec = 1'b0;
      check("b2b_busy_on_accept", 32'(i2c_busy), 32'd1);
      cycle();
      cycle();
      check("b2b_start_q1_sda", 32'(sda_o), 32'd1);
      cycle();
      check("b2b_start_q2_sda", 32'(sda_o), 32'd0);
      check("b2b_start_q2_scl", 32'(scl), 32'd1);
      lat = -1;
      for (int n = 4; n <= 400; n++) begin
         cycle();
         if (i2c_done === 1'b1) begin
            lat = n;
            break;
         end
      end
      check("b2b_latency", 32'(lat), 32'd117);
      repeat (3) cycle();
      check("b2b_nbytes", 32'(bytes_q.size() - base), 32'd6);
      if (bytes_q.size() >= base + 6) begin
         check("b2b_id", 32'(bytes_q[base + 3]), 32'h42);
         check("b2b_addr", 32'(bytes_q[base + 4]), 32'h15);
         check("b2b_data", 32'(bytes_q[base + 5]), 32'h00);
      end
      check("b2b_dones", 32'(done_cnt - d0), 32'd2);

      // Reset mid-transaction.
      i2c_data = 16'h1280;
      i2c_exec = 1'b1;
      cycle();
      i2c_exec = 1'b0;
      repeat (50) cycle();
      rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;
      check("midrst_scl", 32'(scl), 32'd1);
      check("midrst_sda_o", 32'(sda_o), 32'd1);
      check("midrst_sda_oe", 32'(sda_oe), 32'd1);
      check("midrst_busy", 32'(i2c_busy), 32'd0);
      check("midrst_done", 32'(i2c_done), 32'd0);
      check("midrst_ack_err", 32'(ack_err), 32'd0);
      cycle();
      check("midrst_busy_after", 32'(i2c_busy), 32'd0);

      // Divider instance (DIV=4).
      exec4 = 1'b1;
      cycle();
      exec4 = 1'b0;
      lat4 = -1; r1 = -1; r2 = -1; ps = scl4;
      for (int n = 1; n <= 600; n++) begin
         cycle();
         if (!ps && scl4) begin
            if (r1 < 0) r1 = n;
            else if (r2 < 0) r2 = n;
         end
         ps = scl4;
         if (done4 === 1'b1) begin
            lat4 = n;
            break;
         end
      end
      check("div4_latency", 32'(lat4), 32'd465);
      check("div4_scl_period", 32'(r2 - r1), 32'd16);
      check("div4_ack_err", 32'(ack_err4), 32'd0);
      check("div4_busy_at_done", 32'(busy4), 32'd0);

      repeat (3) cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
